// File: rtl/sr04_echo_emulator.sv
// HC-SR04 ultrasonic sensor emulator: measures an incoming trigger pulse and answers
// with an echo pulse whose width encodes the distance selected from distance_bus.
module sr04_echo_emulator #(
    parameter int unsigned MIN_TRIG_US    = 10,
    parameter int unsigned BURST_DELAY_US = 200,
    parameter int unsigned US_PER_CM      = 58,
    parameter int unsigned NO_OBJ_US      = 38000,
    parameter int unsigned HOLDOFF_US     = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clock_1MHz,
    input  logic        clock_1MHz_prev,
    input  logic        emu_en,
    input  logic        trig_rx,
    input  logic [3:0]  mux_sensor_select,
    input  logic [63:0] distance_bus,
    output logic        echo_tx,
    output logic        busy,
    output logic        trig_err,
    output logic [7:0]  echo_count
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] TRIG    = 3'd1;
    localparam logic [2:0] BURST   = 3'd2;
    localparam logic [2:0] ECHO    = 3'd3;
    localparam logic [2:0] HOLDOFF = 3'd4;

    localparam logic [15:0] MIN_WIDTH  = 16'(MIN_TRIG_US);
    localparam logic [15:0] BURST_LAST = 16'(BURST_DELAY_US - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);
    localparam logic [15:0] NO_OBJ_LEN = 16'(NO_OBJ_US);
    localparam logic [15:0] CM_SCALE   = 16'(US_PER_CM);

    logic        trig_meta, trig_sync, trig_prev;
    logic        tick, trig_rise, trig_fall;
    logic [2:0]  state, state_n;
    logic [15:0] width, width_n;
    logic [15:0] count, count_n;
    logic [15:0] echo_len, echo_len_n;
    logic [7:0]  distance, distance_n;
    logic [7:0]  sel_distance;
    logic [15:0] len_calc;
    logic [7:0]  echo_count_n;
    logic        echo_n, err_n;

    assign tick      = clock_1MHz & ~clock_1MHz_prev;
    assign trig_rise = trig_sync & ~trig_prev;
    assign trig_fall = ~trig_sync & trig_prev;

    // Out-of-range sensor indices read as "no object" rather than aliasing onto a real sensor
    assign sel_distance = mux_sensor_select[3] ? 8'd0
                                               : distance_bus[{mux_sensor_select[2:0], 3'b000} +: 8];
    assign len_calc     = (sel_distance == 8'd0) ? NO_OBJ_LEN
                                                 : 16'(sel_distance) * CM_SCALE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_meta <= 1'b0;
            trig_sync <= 1'b0;
            trig_prev <= 1'b0;
        end else begin
            trig_meta <= trig_rx;
            trig_sync <= trig_meta;
            trig_prev <= trig_sync;
        end
    end

    always_comb begin
        state_n      = state;
        width_n      = width;
        count_n      = count;
        echo_len_n   = echo_len;
        distance_n   = distance;
        echo_count_n = echo_count;
        echo_n       = echo_tx;
        err_n        = 1'b0;
        if (!emu_en) begin
            state_n = IDLE;
            width_n = 16'd0;
            count_n = 16'd0;
            echo_n  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    echo_n = 1'b0;
                    if (trig_rise) begin
                        state_n = TRIG;
                        width_n = 16'd0;
                    end
                end
                TRIG: begin
                    if (trig_fall) begin
                        if (width >= MIN_WIDTH) begin
                            state_n    = BURST;
                            distance_n = sel_distance;
                            echo_len_n = len_calc;
                            count_n    = 16'd0;
                        end else begin
                            state_n = IDLE;
                            err_n   = 1'b1;
                        end
                    end else if (tick && trig_sync && width != 16'hFFFF) begin
                        width_n = width + 16'd1;
                    end
                end
                BURST: begin
                    if (tick) begin
                        if (count == BURST_LAST) begin
                            state_n = ECHO;
                            echo_n  = 1'b1;
                            count_n = 16'd0;
                        end else begin
                            count_n = count + 16'd1;
                        end
                    end
                end
                // The echo drops in the same clk as its final tick so the width is exact in ticks
                ECHO: begin
                    if (tick) begin
                        if (count == echo_len - 16'd1) begin
                            state_n      = HOLDOFF;
                            echo_n       = 1'b0;
                            count_n      = 16'd0;
                            echo_count_n = echo_count + 8'd1;
                        end else begin
                            count_n = count + 16'd1;
                        end
                    end
                end
                HOLDOFF: begin
                    if (tick) begin
                        if (count == HOLD_LAST) begin
                            state_n = IDLE;
                            count_n = 16'd0;
                        end else begin
                            count_n = count + 16'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    echo_n  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            width      <= 16'd0;
            count      <= 16'd0;
            echo_len   <= 16'd0;
            distance   <= 8'd0;
            echo_count <= 8'd0;
            echo_tx    <= 1'b0;
            busy       <= 1'b0;
            trig_err   <= 1'b0;
        end else begin
            state      <= state_n;
            width      <= width_n;
            count      <= count_n;
            echo_len   <= echo_len_n;
            distance   <= distance_n;
            echo_count <= echo_count_n;
            echo_tx    <= echo_n;
            busy       <= (state_n != IDLE);
            trig_err   <= err_n;
        end
    end

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// Directed bench for sr04_echo_emulator; timing parameters are shortened so the
// 256-echo wrap run fits in a modest simulation, distance scaling stays at 58 ticks/cm.
module tb_sr04_echo_emulator;

    localparam int MIN_T  = 10;
    localparam int BURST  = 20;
    localparam int CM     = 58;
    localparam int NO_OBJ = 3800;
    localparam int HOLD   = 30;
    localparam int LIM    = 60000;

    logic        clk = 1'b0;
    logic        reset;
    logic        clock_1MHz;
    logic        clock_1MHz_prev;
    logic        emu_en;
    logic        trig_rx;
    logic [3:0]  mux_sensor_select;
    logic [63:0] distance_bus;
    logic        echo_tx;
    logic        busy;
    logic        trig_err;
    logic [7:0]  echo_count;

    int checks = 0;
    int errors = 0;
    int tick_div = 1;
    int err_pulses = 0;
    logic [7:0] exp_count = 8'd0;

    sr04_echo_emulator #(
        .MIN_TRIG_US(MIN_T), .BURST_DELAY_US(BURST), .US_PER_CM(CM),
        .NO_OBJ_US(NO_OBJ), .HOLDOFF_US(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .clock_1MHz(clock_1MHz), .clock_1MHz_prev(clock_1MHz_prev),
        .emu_en(emu_en), .trig_rx(trig_rx), .mux_sensor_select(mux_sensor_select),
        .distance_bus(distance_bus), .echo_tx(echo_tx), .busy(busy),
        .trig_err(trig_err), .echo_count(echo_count)
    );

    always #5 clk = ~clk;

    // Timebase: tick_div=1 gives a tick every clk, tick_div=N gives one every N clks
    initial begin
        int phase;
        phase = 0;
        clock_1MHz = 1'b0;
        clock_1MHz_prev = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % tick_div;
            if (tick_div == 1) begin
                clock_1MHz_prev = 1'b0;
                clock_1MHz = 1'b1;
            end else begin
                clock_1MHz_prev = clock_1MHz;
                clock_1MHz = (phase < tick_div / 2);
            end
        end
    end

    always @(negedge clk) if (trig_err) err_pulses++;

    task automatic pulse_trig(input int n);
        @(negedge clk);
        trig_rx = 1'b1;
        repeat (n) @(negedge clk);
        trig_rx = 1'b0;
    endtask

    // Clks from trig_rx fall to echo rise, echo high clks, busy clks after echo fall
    task automatic measure_echo(output int rise, output int width, output int hold);
        rise = 0; width = -1; hold = -1;
        while (!echo_tx && rise < LIM) begin
            @(negedge clk);
            rise++;
        end
        if (echo_tx) begin
            width = 0;
            while (echo_tx && width < LIM) begin
                width++;
                @(negedge clk);
            end
            hold = 0;
            while (busy && hold < LIM) begin
                hold++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; emu_en = 1'b0; trig_rx = 1'b0;
        mux_sensor_select = 4'd2; distance_bus = 64'd0;
        repeat (4) @(negedge clk);
        checks++; if (echo_tx !== 1'b0) begin errors++; $display("[TB] FAIL reset_echo got %b want 0", echo_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (trig_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %b want 0", trig_err); end
        checks++; if (echo_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", echo_count); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal_echo;
        int r, w, h;
        emu_en = 1'b1;
        distance_bus[23:16] = 8'd10;
        tick_div = 2;
        pulse_trig(24);
        measure_echo(r, w, h);
        exp_count++;
        checks++; if (w !== 2 * 580) begin errors++; $display("[TB] FAIL normal_width_div2 got %0d want %0d", w, 2 * 580); end
        checks++; if (h !== 2 * HOLD) begin errors++; $display("[TB] FAIL normal_hold_div2 got %0d want %0d", h, 2 * HOLD); end
        checks++; if (echo_count !== exp_count) begin errors++; $display("[TB] FAIL normal_count got %0d want %0d", echo_count, exp_count); end
        tick_div = 1;
        pulse_trig(12);
        measure_echo(r, w, h);
        exp_count++;
        // two synchronizer flops plus the edge-detect register precede the burst delay
        checks++; if (r !== BURST + 3) begin errors++; $display("[TB] FAIL normal_rise got %0d want %0d", r, BURST + 3); end
        checks++; if (w !== 580) begin errors++; $display("[TB] FAIL normal_width got %0d want 580", w); end
        checks++; if (h !== HOLD) begin errors++; $display("[TB] FAIL normal_hold got %0d want %0d", h, HOLD); end
        checks++; if (echo_count !== exp_count) begin errors++; $display("[TB] FAIL normal_count2 got %0d want %0d", echo_count, exp_count); end
    endtask

    task automatic test_short_trigger;
        int base, seen;
        base = err_pulses; seen = 0;
        pulse_trig(5);
        repeat (60) begin
            @(negedge clk);
            if (echo_tx) seen++;
        end
        checks++; if (err_pulses - base !== 1) begin errors++; $display("[TB] FAIL short_err_pulses got %0d want 1", err_pulses - base); end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL short_echo got %0d want 0", seen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL short_busy got %b want 0", busy); end
        checks++; if (echo_count !== exp_count) begin errors++; $display("[TB] FAIL short_count got %0d want %0d", echo_count, exp_count); end
    endtask

    task automatic test_no_object;
        int r, w, h;
        distance_bus[23:16] = 8'd0;
        pulse_trig(12);
        measure_echo(r, w, h);
        exp_count++;
        checks++; if (w !== NO_OBJ) begin errors++; $display("[TB] FAIL noobj_zero got %0d want %0d", w, NO_OBJ); end
        distance_bus[15:8] = 8'd7;
        mux_sensor_select = 4'd9;
        pulse_trig(12);
        measure_echo(r, w, h);
        exp_count++;
        checks++; if (w !== NO_OBJ) begin errors++; $display("[TB] FAIL noobj_sel9 got %0d want %0d", w, NO_OBJ); end
        checks++; if (echo_count !== exp_count) begin errors++; $display("[TB] FAIL noobj_count got %0d want %0d", echo_count, exp_count); end
        mux_sensor_select = 4'd2;
    endtask

    task automatic test_max_distance;
        int r, w, h, base, seen;
        base = err_pulses; seen = 0;
        distance_bus[23:16] = 8'd255;
        pulse_trig(12);
        fork
            begin
                repeat (300) @(negedge clk);
                pulse_trig(12);
            end
        join_none
        measure_echo(r, w, h);
        exp_count++;
        repeat (100) begin
            @(negedge clk);
            if (busy) seen++;
        end
        checks++; if (w !== 14790) begin errors++; $display("[TB] FAIL max_width got %0d want 14790", w); end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL retrig_busy got %0d want 0", seen); end
        checks++; if (err_pulses - base !== 0) begin errors++; $display("[TB] FAIL retrig_err got %0d want 0", err_pulses - base); end
        checks++; if (echo_count !== exp_count) begin errors++; $display("[TB] FAIL max_count got %0d want %0d", echo_count, exp_count); end
    endtask

    task automatic test_disable_reset_mid_echo;
        int r, w, h;
        distance_bus[23:16] = 8'd10;
        pulse_trig(12);
        r = 0;
        while (!echo_tx && r < LIM) begin @(negedge clk); r++; end
        repeat (100) @(negedge clk);
        emu_en = 1'b0;
        @(negedge clk);
        checks++; if (echo_tx !== 1'b0) begin errors++; $display("[TB] FAIL disable_echo got %b want 0", echo_tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL disable_busy got %b want 0", busy); end
        checks++; if (echo_count !== exp_count) begin errors++; $display("[TB] FAIL disable_count got %0d want %0d", echo_count, exp_count); end
        emu_en = 1'b1;
        pulse_trig(12);
        measure_echo(r, w, h);
        exp_count++;
        checks++; if (w !== 580) begin errors++; $display("[TB] FAIL after_disable_width got %0d want 580", w); end
        pulse_trig(12);
        r = 0;
        while (!echo_tx && r < LIM) begin @(negedge clk); r++; end
        repeat (100) @(negedge clk);
        reset = 1'b0;
        #1;
        exp_count = 8'd0;
        checks++; if (echo_tx !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid_echo got %b want 0", echo_tx); end
        checks++; if (echo_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_mid_count got %0d want 0", echo_count); end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        pulse_trig(12);
        measure_echo(r, w, h);
        exp_count++;
        checks++; if (w !== 580) begin errors++; $display("[TB] FAIL after_reset_width got %0d want 580", w); end
        checks++; if (echo_count !== exp_count) begin errors++; $display("[TB] FAIL after_reset_count got %0d want %0d", echo_count, exp_count); end
    endtask

    task automatic test_enable_with_trig_high;
        int seen;
        seen = 0;
        emu_en = 1'b0;
        @(negedge clk);
        trig_rx = 1'b1;
        repeat (5) @(negedge clk);
        emu_en = 1'b1;
        repeat (20) @(negedge clk);
        trig_rx = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (busy || echo_tx) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL stale_trig_busy got %0d want 0", seen); end
    endtask

    task automatic test_counter_wrap;
        int r, w, h;
        logic [7:0] start;
        start = exp_count;
        distance_bus[23:16] = 8'd1;
        for (int i = 0; i < 256; i++) begin
            pulse_trig(12);
            measure_echo(r, w, h);
            exp_count++;
            if (exp_count == 8'd0) begin
                checks++; if (echo_count !== 8'd0) begin errors++; $display("[TB] FAIL wrap_zero got %0d want 0", echo_count); end
            end
        end
        checks++; if (echo_count !== start) begin errors++; $display("[TB] FAIL wrap_final got %0d want %0d", echo_count, start); end
        checks++; if (w !== CM) begin errors++; $display("[TB] FAIL wrap_width got %0d want %0d", w, CM); end
    endtask

    initial begin
        test_reset();
        test_normal_echo();
        test_short_trigger();
        test_no_object();
        test_max_distance();
        test_disable_reset_mid_echo();
        test_enable_with_trig_high();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr04_echo_emulator.md
SR04_ECHO_EMULATOR -- requirements
Module: sr04_echo_emulator

Interface
REQ-001 Parameter MIN_TRIG_US, default 10: minimum accepted trigger width in 1 MHz ticks.
REQ-002 Parameter BURST_DELAY_US, default 200: ticks from trigger acceptance to echo rise.
REQ-003 Parameter US_PER_CM, default 58: echo ticks per centimetre.
REQ-004 Parameter NO_OBJ_US, default 38000: echo width in ticks for distance 0 or an invalid sensor index.
REQ-005 Parameter HOLDOFF_US, default 1000: dead time in ticks after echo fall.
REQ-006 Port clk, input, 1: system clock, the only clock.
REQ-007 Port reset, input, 1: asynchronous, active-low reset.
REQ-008 Port clock_1MHz, input, 1: 1 MHz timebase level, synchronous to clk.
REQ-009 Port clock_1MHz_prev, input, 1: clock_1MHz delayed one clk.
REQ-010 Port emu_en, input, 1: emulator enable.
REQ-011 Port trig_rx, input, 1: asynchronous trigger from the sensor controller.
REQ-012 Port mux_sensor_select, input, 4: index of the sensor being triggered.
REQ-013 Port distance_bus, input, 64: eight 8-bit distances in cm; sensor i is at bits [8i+7:8i].
REQ-014 Port echo_tx, output, 1: emulated echo pulse.
REQ-015 Port busy, output, 1: high in any state other than IDLE.
REQ-016 Port trig_err, output, 1: one-clk pulse when a trigger is rejected as too short.
REQ-017 Port echo_count, output, 8: count of completed echoes, wraps 255 -> 0.

Function
REQ-018 tick SHALL equal clock_1MHz AND NOT clock_1MHz_prev; all timing counters SHALL advance only on tick.
REQ-019 trig_rx SHALL pass through a 2-flop synchronizer; edge detection SHALL use the synchronized value only.
REQ-020 The FSM SHALL have five states: IDLE, TRIG, BURST, ECHO, HOLDOFF.
REQ-021 IDLE -> TRIG on a synchronized trig rising edge while emu_en=1; the width counter SHALL clear on entry.
REQ-022 In TRIG, the 16-bit width counter SHALL increment per tick while trig is high and saturate at 0xFFFF.
REQ-023 On trig falling edge with width >= MIN_TRIG_US: TRIG -> BURST, and the selected distance SHALL be latched.
REQ-024 On trig falling edge with width < MIN_TRIG_US: trig_err=1 for one clk, then TRIG -> IDLE.
REQ-025 Latched distance SHALL be distance_bus byte mux_sensor_select[2:0] when mux_sensor_select[3]=0; otherwise it SHALL be 0.
REQ-026 The echo length SHALL be computed once at latch as a 16-bit value: D*US_PER_CM if D != 0, else NO_OBJ_US.
REQ-027 The product SHALL be unsigned, at least 14 bits wide; 255*58 = 14790 SHALL fit without truncation.
REQ-028 BURST -> ECHO on the BURST_DELAY_US-th tick after entry; echo_tx SHALL rise in the same clk.
REQ-029 In ECHO, echo_tx SHALL stay high for exactly the echo length in ticks, then fall in the clk of the final tick.
REQ-030 On that final tick: ECHO -> HOLDOFF, and echo_count SHALL increment.
REQ-031 HOLDOFF -> IDLE after HOLDOFF_US ticks.
REQ-032 Trigger edges in BURST, ECHO and HOLDOFF SHALL be ignored; they do not queue and do not raise trig_err.
REQ-033 emu_en=0 in any state SHALL force IDLE on the next clk, with echo_tx=0, no echo_count increment, and no trig_err.
REQ-034 Trig already high when emu_en rises SHALL NOT start TRIG; a fresh rising edge is required.
REQ-035 echo_tx, busy and trig_err SHALL be registered outputs, glitch-free.

Reset
REQ-036 reset=0 SHALL asynchronously force: state IDLE, echo_tx=0, busy=0, trig_err=0, echo_count=0, synchronizer flops 0, all counters and latches 0.
REQ-037 Reset asserted mid-pulse SHALL drop echo_tx immediately, with no increment.
REQ-038 After reset release, the first trigger accepted SHALL be a fresh rising edge.

Verification
REQ-039 Scenario 1, normal echo.
- Stimulus: emu_en=1, sel=2, byte2=10, 12 us trig.
- Response: echo rises 200 ticks after trig fall and is high 580 ticks; echo_count=1; busy low 1000 ticks after echo fall.
REQ-040 Scenario 2, short trigger.
- Stimulus: 5 us trig.
- Response: one trig_err pulse, no echo, busy returns to 0, echo_count unchanged.
REQ-041 Scenario 3, no object.
- Stimulus: byte2=0, then separately sel=9.
- Response: echo high 38000 ticks in both cases.
REQ-042 Scenario 4, maximum distance and busy retrigger.
- Stimulus: byte=255; retrigger during ECHO.
- Response: echo width 14790 ticks, the retrigger is ignored, echo_count +1 only.
REQ-043 Scenario 5, disable and reset mid-echo.
- Stimulus: emu_en=0 mid-echo; separately, reset low mid-echo.
- Response: echo_tx=0 next clk (disable) or immediately (reset); IDLE; echo_count unchanged by disable and 0 after reset.
- Then: the next valid trigger produces a normal echo.
REQ-044 Scenario 6, counter wrap.
- Stimulus: 256 consecutive valid triggers.
- Response: echo_count wraps to 0.
